// File: rtl/window_loader_if.sv
// Window loader bus: raster pixel stream in, assembled WIN x WIN window out.
// The loader connects through the master modport; the pixel source and window
// consumer connect through the slave modport.
interface window_loader_if #(
  parameter int WIN   = 16,
  parameter int PIX_W = 8
);
  logic                               clear;
  logic [PIX_W-1:0]                   pix_in;
  logic                               pix_valid;
  logic                               pix_ready;
  logic [WIN-1:0][WIN-1:0][PIX_W-1:0] window_data;
  logic                               win_valid;
  logic                               win_ready;
  logic [15:0]                        win_count;

  // Loader side.
  modport master (
    input  clear, pix_in, pix_valid, win_ready,
    output pix_ready, window_data, win_valid, win_count
  );

  // Pixel source / window consumer side.
  modport slave (
    output clear, pix_in, pix_valid, win_ready,
    input  pix_ready, window_data, win_valid, win_count
  );
endinterface

// File: rtl/window_loader.sv
// window_loader: assembles a WIN x WIN window of PIX_W-bit pixels from a
// raster-order stream and presents it as one packed bus with valid/ready,
// holding it stable until the downstream (mean-subtraction) stage consumes it.
// Optional feature: define WIN_LOADER_PINGPONG_EN for two alternating window
// banks (one fills while the other is presented). Default is a single bank.
module window_loader #(
  parameter int WIN   = 16,
  parameter int PIX_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  window_loader_if.master bus
);
  localparam int                 IDX_W = $clog2(WIN);
  localparam logic [IDX_W-1:0]   LAST  = IDX_W'(WIN - 1);

  logic [IDX_W-1:0] row;
  logic [IDX_W-1:0] col;
  logic [15:0]      count;
  logic             pix_ready;
  logic             win_valid;
  logic             accept;
  logic             handoff;
  logic             last_pix;

  assign last_pix = (row == LAST) && (col == LAST);

  // Handshake decode; clear overrides both a pixel accept and a handoff.
  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    accept  = 1'b0;
    handoff = 1'b0;
    if (!bus.clear) begin
      accept  = bus.pix_valid && pix_ready;
      handoff = win_valid && bus.win_ready;
    end
  end

  // Raster position of the next pixel and the count of windows handed off.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row   <= '0;
      col   <= '0;
      count <= '0;
    end else if (bus.clear) begin
      row <= '0;
      col <= '0;
    end else begin
      if (accept) begin
        col <= (col == LAST) ? '0 : col + 1'b1;
        if (col == LAST) row <= (row == LAST) ? '0 : row + 1'b1;
      end
      if (handoff) count <= count + 16'd1;
    end
  end

`ifdef WIN_LOADER_PINGPONG_EN
  // Two banks; fill_sel is the bank being written, out_sel the oldest full bank.
  logic [1:0][WIN-1:0][WIN-1:0][PIX_W-1:0] bank;
  logic [1:0]                              full;
  logic                                    fill_sel;
  logic                                    out_sel;

  assign pix_ready       = !full[fill_sel];
  assign win_valid       = full[out_sel];
  assign bus.window_data = bank[out_sel];

  // Bank store and full flags; banks alternate strictly, bank A (0) first.
  // NOTE: the pixel store is reset because window_data must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank     <= '0;
      full     <= '0;
      fill_sel <= 1'b0;
      out_sel  <= 1'b0;
    end else if (bus.clear) begin
      full     <= '0;
      fill_sel <= 1'b0;
      out_sel  <= 1'b0;
    end else begin
      if (accept) bank[fill_sel][row][col] <= bus.pix_in;
      // Handoff and completion always touch different banks, so both may fire.
      if (handoff) begin
        full[out_sel] <= 1'b0;
        out_sel       <= ~out_sel;
      end
      if (accept && last_pix) begin
        full[fill_sel] <= 1'b1;
        fill_sel       <= ~fill_sel;
      end
    end
  end
`else
  typedef enum logic {FILL, FULL} state_t;

  state_t                             state;
  state_t                             state_next;
  logic [WIN-1:0][WIN-1:0][PIX_W-1:0] win_q;

  assign pix_ready       = (state == FILL);
  assign win_valid       = (state == FULL);
  assign bus.window_data = win_q;

  // Next state: FULL after the last pixel, FILL after a handoff or a clear.
  always_comb begin
    state_next = state;
    if (bus.clear)                                  state_next = FILL;
    else if (state == FILL && accept && last_pix)   state_next = FULL;
    else if (state == FULL && handoff)              state_next = FILL;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_next;
  end

  // Window store; old contents are overwritten pixel by pixel on the next fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      win_q           <= '0;
    else if (accept) win_q[row][col] <= bus.pix_in;
  end
`endif

  assign bus.pix_ready = pix_ready;
  assign bus.win_valid = win_valid;
  assign bus.win_count = count;
endmodule

// File: tb/tb_window_loader.sv
// Testbench for window_loader: table-driven window fills plus hand-written
// clear/reset sequences, checked against a cycle model and a pixel scoreboard.
module tb_window_loader;
  localparam int WIN    = 16;
  localparam int PIX_W  = 8;
  localparam int NPIX   = WIN * WIN;
  localparam int M_RAMP = 0;
  localparam int M_CONST = 1;
  localparam int M_RAND = 2;

  typedef struct {
    string       name;
    int          mode;
    logic [7:0]  val;
    int          stall;
    logic [7:0]  exp_35;
    logic [15:0] exp_cnt;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state and scoreboard.
  logic [7:0]  exp_win [WIN][WIN];
  logic [7:0]  sb_q [$];
  bit          m_full;
  int          m_idx;
  logic [15:0] m_count;
  int          dut_acc;
  vec_t        vecs [3];
  logic [7:0]  pp_q [$];
  int          pp_drops;
  int          pp_n;

  window_loader_if #(.WIN(WIN), .PIX_W(PIX_W)) bus ();

  window_loader #(.WIN(WIN), .PIX_W(PIX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int win_diff();
    int d = 0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        if (bus.window_data[r][c] !== exp_win[r][c]) d++;
    return d;
  endfunction

  function automatic int count_ne(input logic [7:0] v);
    int d = 0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        if (bus.window_data[r][c] !== v) d++;
    return d;
  endfunction

  // One clock: advance the model on the inputs now driven, then compare after the edge.
  task automatic tick();
    bit         done;
    int         d;
    logic [7:0] e;
    done = 0;
    d    = 0;
    if (bus.pix_valid && bus.pix_ready && !bus.clear) dut_acc++;
    if (bus.clear) begin
      m_idx  = 0;
      m_full = 0;
      sb_q.delete();
    end else if (!m_full) begin
      if (bus.pix_valid) begin
        exp_win[m_idx / WIN][m_idx % WIN] = bus.pix_in;
        sb_q.push_back(bus.pix_in);
        m_idx++;
        if (m_idx == NPIX) begin
          m_full = 1;
          done   = 1;
        end
      end
    end else if (bus.win_ready) begin
      m_full = 0;
      m_idx  = 0;
      m_count++;
    end
    @(posedge clk);
    #1;
    check("pix_ready", bus.pix_ready, m_full ? 0 : 1);
    check("win_valid", bus.win_valid, m_full ? 1 : 0);
    check("win_count", bus.win_count, m_count);
    check("window_data", win_diff(), 0);
    if (done) begin
      for (int i = 0; i < NPIX; i++) begin
        e = sb_q.pop_front();
        if (bus.window_data[i / WIN][i % WIN] !== e) d++;
      end
      check("sb_window", d, 0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_valid", bus.win_valid, 0);
    check("rst_count", bus.win_count, 0);
    check("rst_window", count_ne(8'h00), 0);
    m_full  = 0;
    m_idx   = 0;
    m_count = '0;
    sb_q.delete();
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++) exp_win[r][c] = 8'h00;
    bus.clear     = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in    = 8'h00;
    bus.win_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_pix_ready", bus.pix_ready, 1);
  endtask

  // Stream pixels until target accepts (or a complete window when target==NPIX).
  task automatic fill(input int mode, input logic [7:0] val, input int target);
    int budget;
    budget  = 4000;
    dut_acc = 0;
    while (((target == NPIX) ? !m_full : (m_idx < target)) && budget > 0) begin
      bus.pix_valid = (mode == M_RAND) ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.pix_in    = (mode == M_RAMP) ? 8'(m_idx) : val;
      bus.win_ready = (mode == M_RAND) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      budget--;
    end
    bus.pix_valid = 1'b0;
    bus.win_ready = 1'b0;
    check("accepts", dut_acc, target);
  endtask

  initial begin
    bus.clear     = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in    = 8'h00;
    bus.win_ready = 1'b0;
    do_reset();

`ifdef WIN_LOADER_PINGPONG_EN
    // Three back-to-back windows with the consumer always ready.
    pp_drops      = 0;
    bus.win_ready = 1'b1;
    bus.pix_valid = 1'b1;
    for (int i = 0; i < 3 * NPIX + 20; i++) begin
      bus.pix_valid = (i < 3 * NPIX);
      bus.pix_in    = 8'(i / NPIX + 1);
      if (bus.pix_valid && !bus.pix_ready) pp_drops++;
      if (bus.win_valid) begin
        if (pp_q.size() == 0) check("pp_unexpected_window", bus.win_valid, 0);
        else begin
          check("pp_order", bus.window_data[0][0], pp_q[0]);
          check("pp_uniform", count_ne(pp_q[0]), 0);
          void'(pp_q.pop_front());
        end
      end
      if (i < 3 * NPIX && (i % NPIX) == NPIX - 1) pp_q.push_back(8'(i / NPIX + 1));
      @(posedge clk);
      #1;
    end
    check("pp_drops", pp_drops, 0);
    check("pp_count", bus.win_count, 3);
    check("pp_pending", pp_q.size(), 0);

    // Consumer stalled: both banks fill, then the loader stops accepting.
    do_reset();
    bus.pix_valid = 1'b1;
    bus.pix_in    = 8'h5A;
    pp_n          = 0;
    for (int i = 0; i < 600; i++) begin
      if (bus.pix_ready) pp_n++;
      @(posedge clk);
      #1;
    end
    check("pp_accepts", pp_n, 2 * NPIX);
    check("pp_ready_low", bus.pix_ready, 0);
    check("pp_valid", bus.win_valid, 1);
    bus.pix_valid = 1'b0;
`else
    vecs[0] = '{"ramp",    M_RAMP,  8'h00, 20, 8'h35, 16'd1};
    vecs[1] = '{"a5_rand", M_RAND,  8'hA5, 0,  8'hA5, 16'd2};
    vecs[2] = '{"const3c", M_CONST, 8'h3C, 3,  8'h3C, 16'd3};

    for (int i = 0; i < 3; i++) begin
      fill(vecs[i].mode, vecs[i].val, NPIX);
      check({vecs[i].name, "_w35"}, bus.window_data[3][5], vecs[i].exp_35);
      // Hold while FULL; offered pixels must be ignored.
      bus.pix_valid = 1'b1;
      bus.pix_in    = 8'hEE;
      repeat (vecs[i].stall) tick();
      bus.pix_valid = 1'b0;
      bus.win_ready = 1'b1;
      tick();
      bus.win_ready = 1'b0;
      check({vecs[i].name, "_count"}, bus.win_count, vecs[i].exp_cnt);
      check({vecs[i].name, "_ready"}, bus.pix_ready, 1);
    end

    // Clear after 100 accepts; a pixel offered with clear is discarded.
    fill(M_CONST, 8'h77, 100);
    bus.clear     = 1'b1;
    bus.pix_valid = 1'b1;
    bus.pix_in    = 8'hEE;
    tick();
    bus.clear     = 1'b0;
    bus.pix_valid = 1'b0;
    check("clr_count", bus.win_count, 16'd3);
    fill(M_CONST, 8'h11, NPIX);
    check("clr_all11", count_ne(8'h11), 0);

    // Clear during a handoff cancels it.
    bus.clear     = 1'b1;
    bus.win_ready = 1'b1;
    tick();
    bus.clear     = 1'b0;
    bus.win_ready = 1'b0;
    check("clr_handoff_count", bus.win_count, 16'd3);
    check("clr_handoff_valid", bus.win_valid, 0);

    // Reset mid-fill, then a full window from pixel 0, then reset while FULL.
    fill(M_RAMP, 8'h00, 77);
    do_reset();
    fill(M_RAMP, 8'h00, NPIX);
    check("rst_refill_w00", bus.window_data[0][0], 8'h00);
    check("rst_refill_w35", bus.window_data[3][5], 8'h35);
    check("rst_refill_wff", bus.window_data[15][15], 8'hFF);
    do_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
